// File: rtl/mux_sel_scanner_if.sv
// mux_sel_scanner_if -- bundles the scanner's control, mux and frame signals.
//   start, mode_cont : scan request / continuous-restart enable
//   s, mux_out       : select to the 4:1 mux and the mux output it returns
//   frame, frame_valid, frame_ready : captured 4-bit frame and its handshake
//   busy             : scanner is settling or holding a frame
//   ch_mask          : channel enable mask (only when SCAN_MASK_EN is defined)
// Modports: master = scanner side, slave = environment side.
interface mux_sel_scanner_if;
  logic       start;
  logic       mode_cont;
  logic [1:0] s;
  logic       mux_out;
  logic [3:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
`ifdef SCAN_MASK_EN
  logic [3:0] ch_mask;

  modport master (
    input  start, mode_cont, mux_out, frame_ready, ch_mask,
    output s, frame, frame_valid, busy
  );
  modport slave (
    output start, mode_cont, mux_out, frame_ready, ch_mask,
    input  s, frame, frame_valid, busy
  );
`else
  modport master (
    input  start, mode_cont, mux_out, frame_ready,
    output s, frame, frame_valid, busy
  );
  modport slave (
    output start, mode_cont, mux_out, frame_ready,
    input  s, frame, frame_valid, busy
  );
`endif
endinterface

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner -- drives the select of a 4:1 mux, holds each channel for
// DWELL cycles, samples the mux output on the last cycle of each dwell and
// assembles the samples into a 4-bit frame (bit k = sample taken while s == k).
// The frame is offered with valid/ready; mode_cont restarts the scan at the
// handshake without an idle cycle.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mux_sel_scanner_if.master (start, mode_cont, s, mux_out, frame,
//         frame_valid, frame_ready, busy[, ch_mask])
// Parameter DWELL (1..255): cycles the select is held per channel.
// Optional macro SCAN_MASK_EN: adds bus.ch_mask; disabled channels are skipped
// and read as 0 in the frame.
module mux_sel_scanner #(
  parameter int DWELL = 2
) (
  input  logic               clk,
  input  logic               rst,
  mux_sel_scanner_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  // Lowest enabled channel at or above lo; result is {found, channel}.
  function automatic logic [2:0] find_from(input logic [3:0] mask, input logic [2:0] lo);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= lo)) begin
        r = {1'b1, 2'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t     state_r, state_nxt_s;
  logic [1:0] ch_r, ch_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic [3:0] shadow_r, shadow_nxt_s;
  logic [3:0] frame_r, frame_nxt_s;
  logic       frame_valid_r, frame_valid_nxt_s;
  logic [1:0] s_r, s_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic       begin_scan_s;
  logic [3:0] sample_s;
  logic [2:0] next_ch_s;
  logic [2:0] first_ch_s;
  logic [3:0] scan_mask_s;
  logic [3:0] start_mask_s;

`ifdef SCAN_MASK_EN
  logic [3:0] mask_r, mask_nxt_s;
  // The running scan uses the mask captured at its start; a new scan uses the live input.
  assign scan_mask_s  = mask_r;
  assign start_mask_s = bus.ch_mask;
`else
  // Without masking every channel is always scanned.
  assign scan_mask_s  = 4'b1111;
  assign start_mask_s = 4'b1111;
`endif

  assign bus.s           = s_r;
  assign bus.frame       = frame_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.busy        = busy_r;

  // Next-state and next-output logic for the scan FSM.
  always_comb begin
    state_nxt_s       = state_r;
    ch_nxt_s          = ch_r;
    cnt_nxt_s         = cnt_r;
    shadow_nxt_s      = shadow_r;
    frame_nxt_s       = frame_r;
    frame_valid_nxt_s = frame_valid_r;
    s_nxt_s           = s_r;
    busy_nxt_s        = busy_r;
    begin_scan_s      = 1'b0;
`ifdef SCAN_MASK_EN
    mask_nxt_s        = mask_r;
`endif
    // Shadow with the current channel's sample merged in; becomes the frame on the last channel.
    sample_s          = shadow_r;
    sample_s[ch_r]    = bus.mux_out;
    next_ch_s         = find_from(scan_mask_s, {1'b0, ch_r} + 3'd1);
    first_ch_s        = find_from(start_mask_s, 3'd0);

    case (state_r)
      IDLE: begin
        s_nxt_s           = 2'd0;
        busy_nxt_s        = 1'b0;
        frame_valid_nxt_s = 1'b0;
        if (bus.start) begin
          begin_scan_s = 1'b1;
        end else begin
          begin_scan_s = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_r == DWELL_LAST) begin
          shadow_nxt_s = sample_s;
          cnt_nxt_s    = 8'd0;
          if (next_ch_s[2]) begin
            ch_nxt_s = next_ch_s[1:0];
            s_nxt_s  = next_ch_s[1:0];
          end else begin
            // Last enabled channel sampled: publish; s stays on that channel.
            state_nxt_s       = HOLD;
            frame_nxt_s       = sample_s;
            frame_valid_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      HOLD: begin
        if (frame_valid_r && bus.frame_ready) begin
          frame_valid_nxt_s = 1'b0;
          if (bus.mode_cont) begin
            begin_scan_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
            s_nxt_s     = 2'd0;
            busy_nxt_s  = 1'b0;
          end
        end else begin
          begin_scan_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s       = IDLE;
        s_nxt_s           = 2'd0;
        busy_nxt_s        = 1'b0;
        frame_valid_nxt_s = 1'b0;
      end
    endcase

    // Common entry into a new scan, from IDLE or from a continuous restart.
    if (begin_scan_s) begin
      shadow_nxt_s = 4'd0;
      cnt_nxt_s    = 8'd0;
      busy_nxt_s   = 1'b1;
`ifdef SCAN_MASK_EN
      mask_nxt_s   = bus.ch_mask;
`endif
      if (first_ch_s[2]) begin
        state_nxt_s = SETTLE;
        ch_nxt_s    = first_ch_s[1:0];
        s_nxt_s     = first_ch_s[1:0];
      end else begin
        // Nothing enabled: an all-zero frame is ready immediately.
        state_nxt_s       = HOLD;
        ch_nxt_s          = 2'd0;
        s_nxt_s           = 2'd0;
        frame_nxt_s       = 4'd0;
        frame_valid_nxt_s = 1'b1;
      end
    end else begin
      shadow_nxt_s = shadow_nxt_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      ch_r          <= 2'd0;
      cnt_r         <= 8'd0;
      shadow_r      <= 4'd0;
      frame_r       <= 4'd0;
      frame_valid_r <= 1'b0;
      s_r           <= 2'd0;
      busy_r        <= 1'b0;
`ifdef SCAN_MASK_EN
      mask_r        <= 4'd0;
`endif
    end else begin
      state_r       <= state_nxt_s;
      ch_r          <= ch_nxt_s;
      cnt_r         <= cnt_nxt_s;
      shadow_r      <= shadow_nxt_s;
      frame_r       <= frame_nxt_s;
      frame_valid_r <= frame_valid_nxt_s;
      s_r           <= s_nxt_s;
      busy_r        <= busy_nxt_s;
`ifdef SCAN_MASK_EN
      mask_r        <= mask_nxt_s;
`endif
    end
  end

endmodule

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Upstream/downstream companion of the 4:1 select mux: drives the mux's 2-bit select, waits a programmable settle time per channel, and samples the mux's 1-bit output.
- Assembles the four sampled bits into a 4-bit frame.
- Hands the frame downstream with a valid/ready handshake.
- Supports single-shot and continuous scanning.

Parameters:
- DWELL, 2: cycles the select is held per channel before the sample is taken; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to begin a scan; honoured only in IDLE
- mode_cont  input  1  1 = restart the scan automatically after each frame handshake; sampled at handshake
- s  output  2  select to the 4:1 mux
- mux_out  input  1  output of the 4:1 mux
- frame  output  4  captured frame; bit k = value of mux_out while s == k
- frame_valid  output  1  frame is available
- frame_ready  input  1  downstream accepts the frame
- busy  output  1  high in SETTLE and HOLD

Behaviour:
- Reset is synchronous and active-high: rst high at a rising edge forces the following, overriding all other inputs in that cycle:
  - state = IDLE
  - s = 0, frame = 0, frame_valid = 0, busy = 0
  - internal channel counter, dwell counter and shadow register = 0
- Reset mid-scan or during HOLD discards any partial or pending frame.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - s = 0, busy = 0, frame_valid = 0.
  - start = 1 → SETTLE with ch = 0, cnt = 0.
- SETTLE:
  - s = ch; busy = 1.
  - Each cycle: cnt increments.
  - When cnt == DWELL-1: shadow[ch] <= mux_out.
    - If ch < 3: ch increments and cnt returns to 0.
    - If ch == 3: frame <= shadow with bit 3 = mux_out, frame_valid <= 1, go to HOLD.
  - s therefore holds each channel for exactly DWELL cycles; the sample is taken on the last of those cycles.
- Latency: start accepted at edge N → frame_valid high after edge N + 4*DWELL.
- HOLD:
  - frame, frame_valid, s (= 3) and busy held stable until frame_ready = 1.
  - On handshake (frame_valid & frame_ready at an edge):
    - frame_valid clears on that edge.
    - mode_cont = 1 → SETTLE with ch = 0, cnt = 0; no idle bubble.
    - mode_cont = 0 → IDLE.
  - frame keeps its last value after the handshake until overwritten.
- start while busy is ignored and not queued.
- mode_cont changes during SETTLE have no effect until the handshake.
- Counter widths: cnt is 8 bits, ch is 2 bits; no wrap occurs inside a scan because ch stops at 3.

Optional Feature:
- Macro: SCAN_MASK_EN.
- Defined:
  - Adds input ch_mask[3:0], registered when start is accepted or when a continuous restart occurs.
  - Channels with mask bit 0 are skipped: s never takes their value, and their frame bit is 0.
  - Scan order is ascending over the enabled channels.
  - Latency = (number of enabled channels) * DWELL.
  - Mask 4'b0000 → HOLD on the next edge with frame = 0.
  - In HOLD, s holds the last enabled channel, or 0 if no channel was enabled.
- Undefined: no ch_mask port; all four channels are scanned as described above.

Test Plan:
- Reset, DWELL = 2, mux model with in = 4'b1010, start pulse → s sequence 0,0,1,1,2,2,3,3; frame_valid rises 8 cycles after start; frame = 4'b1010; busy = 1 throughout.
- frame_ready held 0 for 5 cycles in HOLD → frame = 1010, frame_valid = 1 and s = 3 are stable all 5 cycles; ready = 1 → valid drops next edge, state IDLE, s = 0.
- mode_cont = 1, in = 1010 then changed to 0101 during the second scan → back-to-back frames 1010 then 0101, with the second scan starting on the cycle after the first handshake.
- start pulsed mid-scan → ignored, only one frame produced; rst asserted while ch = 2 → next cycle s = 0, busy = 0, frame_valid = 0, frame = 0; a fresh start then yields a correct full frame.
- DWELL = 1, in = 4'b0110 → s steps 0,1,2,3 on consecutive cycles; frame = 0110 valid 4 cycles after start.
- SCAN_MASK_EN, ch_mask = 4'b0101, in = 4'b1111, DWELL = 2 → s visits only 0,0,2,2; frame = 0101 after 4 cycles. Mask 0000 → frame = 0 with valid 1 cycle after start.
